// File: rtl/pipe_multiplier.sv
// Pipelined multiplier with a runtime signed/unsigned mode per operand.
// There are four CE-qualified stages: operand capture, magnitude/sign, unsigned
// product, then signing, round-half-up shift and saturation. Valid bits travel
// alongside the data, and all outputs come straight from registers.
module pipe_multiplier #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int OUT_WIDTH = 36,
    parameter int SHIFT     = 0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CE,
    input  logic [A_WIDTH-1:0]           A,
    input  logic [B_WIDTH-1:0]           B,
    input  logic                         A_SIGNED,
    input  logic                         B_SIGNED,
    input  logic                         IN_VALID,
    output logic [A_WIDTH+B_WIDTH:0]     P_FULL,
    output logic [OUT_WIDTH-1:0]         P,
    output logic                         SAT,
    output logic                         OUT_VALID
);

    localparam int MW = A_WIDTH + B_WIDTH;   // unsigned magnitude product
    localparam int PW = MW + 1;              // exact signed product
    localparam int RW = PW + 1;              // one guard bit for the rounding add

    // The rounding constant is 2^(SHIFT-1), or zero when no shift is applied.
    localparam logic [RW-1:0]        RND     = (RW'(1) << SHIFT) >> 1;
    localparam logic signed [RW-1:0] P_MAX   = $signed((RW'(1) << (OUT_WIDTH - 1)) - RW'(1));
    localparam logic signed [RW-1:0] P_MIN   = $signed(RW'(0) - (RW'(1) << (OUT_WIDTH - 1)));
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    // Stage 1 registers
    logic [A_WIDTH-1:0] a_r;
    logic [B_WIDTH-1:0] b_r;
    logic               a_signed_r;
    logic               b_signed_r;
    logic               v1_r;
    // Stage 2 registers
    logic [A_WIDTH-1:0] mag_a_r;
    logic [B_WIDTH-1:0] mag_b_r;
    logic               neg2_r;
    logic               v2_r;
    // Stage 3 registers
    logic [MW-1:0]      mag_r;
    logic               neg3_r;
    logic               v3_r;

    // Stage 2 and 4 combinational intermediates
    logic                        a_neg_s;
    logic                        b_neg_s;
    logic [A_WIDTH-1:0]          mag_a_s;
    logic [B_WIDTH-1:0]          mag_b_s;
    logic [PW-1:0]               full_s;
    logic [RW-1:0]               sum_s;
    logic signed [RW-1:0]        r_s;
    logic [OUT_WIDTH-1:0]        p_s;
    logic                        sat_s;

    // Stage 1: capture the operands, the mode bits and the input valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r        <= '0;
            b_r        <= '0;
            a_signed_r <= 1'b0;
            b_signed_r <= 1'b0;
            v1_r       <= 1'b0;
        end else if (CE) begin
            a_r        <= A;
            b_r        <= B;
            a_signed_r <= A_SIGNED;
            b_signed_r <= B_SIGNED;
            v1_r       <= IN_VALID;
        end
    end

    // Stage 2 logic: find each operand's magnitude. The most-negative value maps
    // to 2^(W-1), which still fits in W unsigned bits.
    always_comb begin
        a_neg_s = a_signed_r & a_r[A_WIDTH-1];
        b_neg_s = b_signed_r & b_r[B_WIDTH-1];
        mag_a_s = a_neg_s ? ((~a_r) + A_WIDTH'(1)) : a_r;
        mag_b_s = b_neg_s ? ((~b_r) + B_WIDTH'(1)) : b_r;
    end

    // Stage 2: register both magnitudes and the sign of the product.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mag_a_r <= '0;
            mag_b_r <= '0;
            neg2_r  <= 1'b0;
            v2_r    <= 1'b0;
        end else if (CE) begin
            mag_a_r <= mag_a_s;
            mag_b_r <= mag_b_s;
            neg2_r  <= a_neg_s ^ b_neg_s;
            v2_r    <= v1_r;
        end
    end

    // Stage 3: compute the exact unsigned product of the magnitudes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mag_r  <= '0;
            neg3_r <= 1'b0;
            v3_r   <= 1'b0;
        end else if (CE) begin
            mag_r  <= {{B_WIDTH{1'b0}}, mag_a_r} * {{A_WIDTH{1'b0}}, mag_b_r};
            neg3_r <= neg2_r;
            v3_r   <= v2_r;
        end
    end

    // Stage 4 logic: apply the sign, round half up while shifting, then clip to OUT_WIDTH.
    // Negating a zero magnitude gives zero, so a zero product is always +0.
    always_comb begin
        full_s = neg3_r ? (PW'(0) - {1'b0, mag_r}) : {1'b0, mag_r};
        sum_s  = {full_s[PW-1], full_s} + RND;
        r_s    = $signed(sum_s) >>> SHIFT;
        if (r_s > P_MAX) begin
            p_s   = OUT_MAX;
            sat_s = 1'b1;
        end else if (r_s < P_MIN) begin
            p_s   = OUT_MIN;
            sat_s = 1'b1;
        end else begin
            p_s   = r_s[OUT_WIDTH-1:0];
            sat_s = 1'b0;
        end
    end

    // Stage 4: register the final outputs and the output valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            P_FULL    <= '0;
            P         <= '0;
            SAT       <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (CE) begin
            P_FULL    <= full_s;
            P         <= p_s;
            SAT       <= sat_s;
            OUT_VALID <= v3_r;
        end
    end

endmodule

// File: doc/pipe_multiplier.md
Name: pipe_multiplier

Overview:
- Parametrised, pipelined successor to the combinational 18x18 sign-magnitude multiplier used in the DSP48A1 model.
- Generalises operand widths and adds a runtime signed/unsigned mode per operand.
- Adds a 4-stage registered pipeline with clock enable and valid tracking, plus rounding, shift and saturation on the output.
- Sits between the pre-adder/input registers and the post-adder/accumulator.

Parameters:
- A_WIDTH, 18, width of operand A (2..32).
- B_WIDTH, 18, width of operand B (2..32).
- OUT_WIDTH, 36, width of rounded/saturated output P (2..A_WIDTH+B_WIDTH+1).
- SHIFT, 0, arithmetic right shift applied to full product before saturation (0..A_WIDTH+B_WIDTH-1).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- CE  input  1  clock enable; when 0 the whole pipeline holds.
- A  input  A_WIDTH  operand A.
- B  input  B_WIDTH  operand B.
- A_SIGNED  input  1  1 = A is two's complement, 0 = A is unsigned.
- B_SIGNED  input  1  1 = B is two's complement, 0 = B is unsigned.
- IN_VALID  input  1  A/B/mode qualify this cycle.
- P_FULL  output  A_WIDTH+B_WIDTH+1  exact signed product.
- P  output  OUT_WIDTH  rounded, shifted, saturated product (signed).
- SAT  output  1  P was clipped this result.
- OUT_VALID  output  1  P_FULL/P/SAT qualify this cycle.

Behaviour:
- One clock CLK; reset RST is synchronous and active-high.
- RST=1 at a rising edge clears every pipeline register, including all valid bits; P_FULL=0, P=0, SAT=0, OUT_VALID=0 on the following cycle.
- RST has priority over CE. Reset mid-operation discards all in-flight results; no partial result appears afterwards.
- Pipeline advances only on edges with CE=1; with CE=0 all registers and outputs hold, including OUT_VALID.
- Latency is exactly 4 CE-enabled edges: a sample taken at CE edge n appears on the outputs after CE edge n+3 (the 4th enabled edge counting the capture edge).
- Throughput is one result per enabled cycle. There is no backpressure beyond CE.
- Data registers load on every enabled edge regardless of valid. Valid bits shift alongside the data. OUT_VALID=0 means outputs are don't-care, but they must be deterministic.
- Stage 1: register A, B, A_SIGNED, B_SIGNED, IN_VALID.
- Stage 2, magnitude and sign:
  - magA = |A| if A_SIGNED and A[MSB]=1, else A, as an A_WIDTH-bit unsigned value. The most-negative value -2^(A_WIDTH-1) yields magnitude 2^(A_WIDTH-1), with no overflow.
  - B is handled the same way.
  - neg = (A_SIGNED & A[MSB]) ^ (B_SIGNED & B[MSB]).
- Stage 3: mag = magA*magB, A_WIDTH+B_WIDTH bits unsigned, exact.
- Stage 4, signing, rounding and saturation:
  - P_FULL = neg ? -mag : mag, sign-extended to A_WIDTH+B_WIDTH+1 bits. Zero product is always +0.
  - If SHIFT>0, r = (P_FULL + 2^(SHIFT-1)) >>> SHIFT (round-half-up, computed in one extra bit); otherwise r = P_FULL.
  - If r > 2^(OUT_WIDTH-1)-1, P = max positive and SAT=1. If r < -2^(OUT_WIDTH-1), P = min negative and SAT=1. Otherwise P = r and SAT=0.
- Mode bits are captured per sample. Mixing modes across consecutive samples is legal and must not corrupt neighbouring results.

Test Plan:
- Defaults, signed×signed A=-131072, B=-131072, IN_VALID=1 -> 4 enabled edges later OUT_VALID=1, P_FULL=P=17179869184, SAT=0.
- Defaults, unsigned×unsigned A=B=262143 -> P_FULL=68718952449, P=34359738367, SAT=1.
- Defaults, back-to-back signed A=-3,B=5 then A=unsigned 262143,B=signed -1 -> P=-15 then P=-262143, on consecutive cycles, in order.
- SHIFT=4, OUT_WIDTH=16, signed 7×5 then -7×5 -> P=2 then P=-2, both with SAT=0. Also 32767×32767 with 18-bit inputs -> P=32767, SAT=1.
- CE stall: issue 3 valid samples, drop CE for 5 cycles after the 2nd edge, then resume -> outputs frozen during the stall, all 3 results emerge in order with total latency of 4 enabled edges and no duplicates.
- Reset mid-stream: RST=1 for 1 cycle with 3 samples in flight -> next cycle P=0, P_FULL=0, SAT=0, OUT_VALID=0, and OUT_VALID stays 0 until 4 enabled edges after new input.
